mul_accumulator: RTL and testbench
==================================

# mul_accumulator

Downstream consumer of the sequential signed multiplier: takes the stream of signed 2·NUMBITS-bit products and accumulates them into a wider signed sum, one dot-product per `product_last`-terminated burst. The block presents the finished sum, its element count and an overflow flag on a valid/ready output port, holding them until the next stage takes them. It sits between the multiplier result register and the vector-result writeback.

## Interface
- `NUMBITS`, 16: operand width of the multiplier. Product width is 2·NUMBITS.
- `ACCBITS`, 40: accumulator width. ACCBITS ≥ 2·NUMBITS is required; elaboration fails otherwise.
- `CNTBITS`, 8: element-counter width.

- `clk` input 1: clock. All state updates occur on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `product_in` input 2·NUMBITS: signed two's-complement product.
- `product_valid` input 1: `product_in` and `product_last` are valid.
- `product_last` input 1: the current beat is the final element of the burst.
- `product_ready` output 1: the block accepts a beat this cycle.
- `acc_out` output ACCBITS: signed final sum.
- `acc_count` output CNTBITS: number of beats in the sum, saturating.
- `acc_overflow` output 1: sticky flag. It is set if any addition in the burst overflowed signed ACCBITS.
- `acc_valid` output 1: the result outputs are valid.
- `acc_ready` input 1: downstream takes the result.

## Operation
- The FSM has two states: ACCUM and HOLD. Reset enters ACCUM.
- In ACCUM:
  - `product_ready` = 1 and `acc_valid` = 0.
  - A beat is accepted when `product_valid` && `product_ready`.
  - An accepted beat sign-extends `product_in` to ACCBITS and adds it to the internal accumulator `acc`. Its counter increments, saturating at 2^CNTBITS−1.
  - An accepted beat sets the internal overflow flag `ovf` when both operands have the same sign and the raw sum has a different sign.
- When a beat is accepted with `product_last` = 1:
  - The final sum (acc + product), count+1 and ovf are registered into `acc_out`, `acc_count` and `acc_overflow`.
  - `acc`, the counter and `ovf` clear to 0.
  - The FSM moves to HOLD.
- In HOLD:
  - `product_ready` = 0, so no beats are accepted.
  - `acc_valid` = 1.
  - `acc_out`, `acc_count` and `acc_overflow` are stable.
- In HOLD, when `acc_ready` = 1, the result is consumed. Next cycle the FSM is in ACCUM and `acc_valid` = 0. Result outputs keep their last value.
- A burst may be a single beat (`product_last` on the first beat).
- `product_valid` = 0 in ACCUM leaves all state unchanged. Gaps inside a burst are allowed.
- `product_last` is ignored when `product_valid` = 0.
- `acc_ready` is ignored in ACCUM.

## Timing
- Reset values: `product_ready` = 0 while reset is asserted and 1 from the first clock edge after deassertion. `acc_valid` = 0, `acc_out` = 0, `acc_count` = 0, `acc_overflow` = 0. State is ACCUM; acc, counter and ovf are 0.
- Latency: `acc_valid` rises in the cycle after the last beat is accepted.
- Throughput: one beat per cycle within a burst. There is exactly one bubble cycle per burst: the HOLD cycle in which `acc_ready` is sampled. With `acc_ready` held at 1, a new burst starts 2 cycles after the previous last beat.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.
- Reset mid-burst or mid-HOLD discards the partial sum and pending result immediately.

## Configuration
- `MUL_ACC_SATURATE_EN` defined:
  - On an overflowing addition, `acc` clamps to +2^(ACCBITS−1)−1 or −2^(ACCBITS−1), according to the operand sign.
  - Subsequent additions continue from the clamped value.
  - `acc_overflow` is still reported.
- `MUL_ACC_SATURATE_EN` undefined:
  - `acc` wraps modulo 2^ACCBITS.
  - `acc_overflow` is reported identically.

## Test plan
- **Basic burst**: products 6, −20, 100 (last) at 1/cycle, `acc_ready` = 1 → one cycle after the last beat: `acc_valid` = 1, `acc_out` = 86, `acc_count` = 3, `acc_overflow` = 0. `product_ready` is low exactly 1 cycle.
- **Single-beat burst**: −32768·1 = 0xFFFF8000 with last → `acc_out` = −32768 sign-extended to 40 bits, `acc_count` = 1.
- **Backpressure**: after a burst, hold `acc_ready` = 0 for 5 cycles → `acc_valid` = 1, outputs stable and `product_ready` = 0 throughout. The input beat offered during this time is not accepted until 1 cycle after `acc_ready` pulses.
- **Overflow**: ACCBITS = 32, three beats of 0x3FFF0001 → `acc_overflow` = 1.
  - With `MUL_ACC_SATURATE_EN`: `acc_out` = 0x7FFFFFFF.
  - Without it: `acc_out` = −1073938429.
- **Counter saturation and gaps**: CNTBITS = 4, 20 beats of 1 with random `product_valid` gaps → `acc_out` = 20, `acc_count` = 15.
- **Reset mid-burst**: assert `reset` after 2 of 4 beats, then replay a full burst of 1, 2, 3, 4 → `acc_out` = 10, `acc_count` = 4.

Source files
------------

// File: rtl/mul_accumulator_if.sv
`default_nettype none
// ============================================================================
//  Module   : mul_accumulator_if
//  Purpose  : Handshake bundle around mul_accumulator. It carries the product
//             stream from the multiplier (valid/ready/last) and the result
//             stream to writeback (valid/ready).
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Signals
//    product_in    [2*NUMBITS] signed product beat
//    product_valid             beat valid
//    product_last              final beat of a burst
//    product_ready             accumulator accepts a beat
//    acc_out       [ACCBITS]   signed final sum
//    acc_count     [CNTBITS]   saturating element count
//    acc_overflow              sticky signed overflow flag for the burst
//    acc_valid                 result valid
//    acc_ready                 downstream takes the result
//  Modports
//    master : producer/consumer side (multiplier + writeback)
//    slave  : the accumulator itself
// ============================================================================
interface mul_accumulator_if #(
    parameter int NUMBITS = 16,
    parameter int ACCBITS = 40,
    parameter int CNTBITS = 8
);
    logic [2*NUMBITS-1:0] product_in;
    logic                 product_valid;
    logic                 product_last;
    logic                 product_ready;
    logic [ACCBITS-1:0]   acc_out;
    logic [CNTBITS-1:0]   acc_count;
    logic                 acc_overflow;
    logic                 acc_valid;
    logic                 acc_ready;

    modport master (
        output product_in, product_valid, product_last, acc_ready,
        input  product_ready, acc_out, acc_count, acc_overflow, acc_valid
    );

    modport slave (
        input  product_in, product_valid, product_last, acc_ready,
        output product_ready, acc_out, acc_count, acc_overflow, acc_valid
    );
endinterface
`default_nettype wire

// File: rtl/mul_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : mul_accumulator
//  Purpose  : Accumulates a burst of signed 2*NUMBITS-bit products into a
//             signed ACCBITS-bit sum. The burst ends on a beat carrying
//             product_last; the sum, beat count and overflow flag are then
//             held on a valid/ready result port until downstream takes them.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk    in  : clock, rising edge
//    reset  in  : asynchronous reset, active low
//    bus    slv : mul_accumulator_if.slave (product and result streams)
//  Build option
//    MUL_ACC_SATURATE_EN : when defined, an overflowing addition clamps the
//                          running sum to the signed extreme; otherwise the
//                          sum wraps modulo 2^ACCBITS. Overflow is flagged
//                          the same way in both builds.
// ============================================================================
module mul_accumulator #(
    parameter int NUMBITS = 16,
    parameter int ACCBITS = 40,
    parameter int CNTBITS = 8
) (
    input  wire logic          clk,
    input  wire logic          reset,
    mul_accumulator_if.slave   bus
);

    generate
        if (ACCBITS < 2 * NUMBITS) begin : g_param_check
            $error("mul_accumulator: ACCBITS must be at least 2*NUMBITS");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [ACCBITS-1:0]   acc_q, acc_d;
    logic [CNTBITS-1:0]   cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic [ACCBITS-1:0]   acc_out_q, acc_out_d;
    logic [CNTBITS-1:0]   acc_count_q, acc_count_d;
    logic                 acc_overflow_q, acc_overflow_d;
    logic                 product_ready_q, product_ready_d;
    logic                 acc_valid_q, acc_valid_d;

    logic                 w_accept;
    logic [ACCBITS-1:0]   w_prod_ext;
    logic [ACCBITS-1:0]   w_sum;
    logic                 w_add_ovf;
    logic [ACCBITS-1:0]   w_acc_next;
    logic [CNTBITS-1:0]   w_cnt_next;

    // product_ready is a flop that mirrors the state, so accept never
    // depends combinationally on anything but registered state.
    assign w_accept   = bus.product_valid && product_ready_q;
    assign w_prod_ext = ACCBITS'($signed(bus.product_in));
    assign w_sum      = acc_q + w_prod_ext;
    // Same-sign operands producing an opposite-sign result.
    assign w_add_ovf  = (acc_q[ACCBITS-1] == w_prod_ext[ACCBITS-1]) &&
                        (w_sum[ACCBITS-1] != acc_q[ACCBITS-1]);
    assign w_cnt_next = (&cnt_q) ? cnt_q : cnt_q + CNTBITS'(1);

`ifdef MUL_ACC_SATURATE_EN
    localparam logic [ACCBITS-1:0] c_ACC_MAX = {1'b0, {(ACCBITS-1){1'b1}}};
    localparam logic [ACCBITS-1:0] c_ACC_MIN = {1'b1, {(ACCBITS-1){1'b0}}};

    // On overflow both operands share the sign, so acc_q's sign picks the rail.
    always_comb begin
        w_acc_next = w_sum;
        if (w_add_ovf) begin
            w_acc_next = acc_q[ACCBITS-1] ? c_ACC_MIN : c_ACC_MAX;
        end
    end
`else
    always_comb begin
        w_acc_next = w_sum;
    end
`endif

    always_comb begin
        state_d        = state_q;
        acc_d          = acc_q;
        cnt_d          = cnt_q;
        ovf_d          = ovf_q;
        acc_out_d      = acc_out_q;
        acc_count_d    = acc_count_q;
        acc_overflow_d = acc_overflow_q;

        case (state_q)
            ST_ACCUM: begin
                if (w_accept) begin
                    if (bus.product_last) begin
                        acc_out_d      = w_acc_next;
                        acc_count_d    = w_cnt_next;
                        acc_overflow_d = ovf_q | w_add_ovf;
                        acc_d          = '0;
                        cnt_d          = '0;
                        ovf_d          = 1'b0;
                        state_d        = ST_HOLD;
                    end else begin
                        acc_d = w_acc_next;
                        cnt_d = w_cnt_next;
                        ovf_d = ovf_q | w_add_ovf;
                    end
                end
            end
            ST_HOLD: begin
                if (bus.acc_ready) begin
                    state_d = ST_ACCUM;
                end
            end
            default: begin
                state_d = ST_ACCUM;
            end
        endcase

        product_ready_d = (state_d == ST_ACCUM);
        acc_valid_d     = (state_d == ST_HOLD);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= ST_ACCUM;
            acc_q           <= '0;
            cnt_q           <= '0;
            ovf_q           <= 1'b0;
            acc_out_q       <= '0;
            acc_count_q     <= '0;
            acc_overflow_q  <= 1'b0;
            product_ready_q <= 1'b0;
            acc_valid_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            acc_q           <= acc_d;
            cnt_q           <= cnt_d;
            ovf_q           <= ovf_d;
            acc_out_q       <= acc_out_d;
            acc_count_q     <= acc_count_d;
            acc_overflow_q  <= acc_overflow_d;
            product_ready_q <= product_ready_d;
            acc_valid_q     <= acc_valid_d;
        end
    end

    assign bus.product_ready = product_ready_q;
    assign bus.acc_valid     = acc_valid_q;
    assign bus.acc_out       = acc_out_q;
    assign bus.acc_count     = acc_count_q;
    assign bus.acc_overflow  = acc_overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mul_accumulator
//  Purpose  : Directed self-checking bench for mul_accumulator. Instance
//             u_dut_a uses the default widths; u_dut_b uses ACCBITS=32 and
//             CNTBITS=4 for the overflow and count-saturation vectors.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mul_accumulator;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    mul_accumulator_if #(.NUMBITS(16), .ACCBITS(40), .CNTBITS(8)) bus_a ();
    mul_accumulator_if #(.NUMBITS(16), .ACCBITS(32), .CNTBITS(4)) bus_b ();

    mul_accumulator #(.NUMBITS(16), .ACCBITS(40), .CNTBITS(8)) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    mul_accumulator #(.NUMBITS(16), .ACCBITS(32), .CNTBITS(4)) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_a(input logic v, input logic [31:0] p, input logic l);
        bus_a.product_valid = v;
        bus_a.product_in    = p;
        bus_a.product_last  = l;
    endtask

    task automatic drive_b(input logic v, input logic [31:0] p, input logic l);
        bus_b.product_valid = v;
        bus_b.product_in    = p;
        bus_b.product_last  = l;
    endtask

    initial begin
        int sent;
        int budget;
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        drive_a(1'b0, 32'd0, 1'b0);
        drive_b(1'b0, 32'd0, 1'b0);
        bus_a.acc_ready = 1'b1;
        bus_b.acc_ready = 1'b1;

        // ---------------- reset state ----------------
        tick();
        tick();
        chk("rst_ready",   {63'd0, bus_a.product_ready}, 64'd0);
        chk("rst_valid",   {63'd0, bus_a.acc_valid},     64'd0);
        chk("rst_out",     {24'd0, bus_a.acc_out},       64'd0);
        chk("rst_count",   {56'd0, bus_a.acc_count},     64'd0);
        chk("rst_ovf",     {63'd0, bus_a.acc_overflow},  64'd0);
        reset = 1'b1;
        tick();
        chk("rel_ready",   {63'd0, bus_a.product_ready}, 64'd1);

        // ---------------- basic burst 6, -20, 100 ----------------
        drive_a(1'b1, 32'd6, 1'b0);
        tick();
        drive_a(1'b1, 32'hFFFF_FFEC, 1'b0);
        tick();
        chk("basic_mid_ready", {63'd0, bus_a.product_ready}, 64'd1);
        drive_a(1'b1, 32'd100, 1'b1);
        tick();
        drive_a(1'b0, 32'd0, 1'b0);
        chk("basic_valid", {63'd0, bus_a.acc_valid},     64'd1);
        chk("basic_ready", {63'd0, bus_a.product_ready}, 64'd0);
        chk("basic_out",   {24'd0, bus_a.acc_out},       64'd86);
        chk("basic_count", {56'd0, bus_a.acc_count},     64'd3);
        chk("basic_ovf",   {63'd0, bus_a.acc_overflow},  64'd0);
        tick();
        chk("basic_consumed_valid", {63'd0, bus_a.acc_valid},     64'd0);
        chk("basic_consumed_ready", {63'd0, bus_a.product_ready}, 64'd1);
        chk("basic_out_kept",       {24'd0, bus_a.acc_out},       64'd86);

        // ---------------- single-beat burst ----------------
        drive_a(1'b1, 32'hFFFF_8000, 1'b1);
        tick();
        chk("single_out",   {24'd0, bus_a.acc_out},   64'h0000_00FF_FFFF_8000);
        chk("single_count", {56'd0, bus_a.acc_count}, 64'd1);

        // ---------------- backpressure, beat 7 offered while held ----------------
        bus_a.acc_ready = 1'b0;
        drive_a(1'b1, 32'd7, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", {63'd0, bus_a.acc_valid},     64'd1);
            chk("bp_ready", {63'd0, bus_a.product_ready}, 64'd0);
            chk("bp_out",   {24'd0, bus_a.acc_out},       64'h0000_00FF_FFFF_8000);
        end
        bus_a.acc_ready = 1'b1;
        tick();
        chk("bp_release_valid", {63'd0, bus_a.acc_valid},     64'd0);
        chk("bp_release_ready", {63'd0, bus_a.product_ready}, 64'd1);
        tick();
        drive_a(1'b0, 32'd0, 1'b0);
        chk("bp_next_valid", {63'd0, bus_a.acc_valid}, 64'd1);
        chk("bp_next_out",   {24'd0, bus_a.acc_out},   64'd7);
        chk("bp_next_count", {56'd0, bus_a.acc_count}, 64'd1);
        tick();

        // ---------------- overflow on 32-bit accumulator ----------------
        for (int i = 0; i < 3; i++) begin
            drive_b(1'b1, 32'h3FFF_0001, (i == 2));
            tick();
        end
        drive_b(1'b0, 32'd0, 1'b0);
        chk("ovf_valid", {63'd0, bus_b.acc_valid},    64'd1);
        chk("ovf_flag",  {63'd0, bus_b.acc_overflow}, 64'd1);
        chk("ovf_count", {60'd0, bus_b.acc_count},    64'd3);
`ifdef MUL_ACC_SATURATE_EN
        chk("ovf_out",   {32'd0, bus_b.acc_out},      64'h7FFF_FFFF);
`else
        chk("ovf_out",   {32'd0, bus_b.acc_out},      64'hBFFD_0003);
`endif
        tick();

        // ---------------- count saturation with valid gaps ----------------
        sent   = 0;
        budget = 0;
        while (sent < 20 && budget < 400) begin
            drive_b(($urandom_range(0, 2) != 0), 32'd1, (sent == 19));
            if (bus_b.product_valid && bus_b.product_ready) sent++;
            tick();
            budget++;
        end
        drive_b(1'b0, 32'd0, 1'b0);
        chk("sat_beats_sent", 64'(sent), 64'd20);
        chk("sat_valid", {63'd0, bus_b.acc_valid},    64'd1);
        chk("sat_out",   {32'd0, bus_b.acc_out},      64'd20);
        chk("sat_count", {60'd0, bus_b.acc_count},    64'd15);
        chk("sat_ovf",   {63'd0, bus_b.acc_overflow}, 64'd0);
        tick();

        // ---------------- reset mid-burst ----------------
        drive_a(1'b1, 32'd1, 1'b0);
        tick();
        drive_a(1'b1, 32'd2, 1'b0);
        tick();
        drive_a(1'b0, 32'd0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_ready", {63'd0, bus_a.product_ready}, 64'd0);
        chk("midrst_out",   {24'd0, bus_a.acc_out},       64'd0);
        tick();
        reset = 1'b1;
        tick();
        chk("midrst_rel_ready", {63'd0, bus_a.product_ready}, 64'd1);
        for (int i = 1; i <= 4; i++) begin
            drive_a(1'b1, 32'(i), (i == 4));
            tick();
        end
        drive_a(1'b0, 32'd0, 1'b0);
        chk("replay_valid", {63'd0, bus_a.acc_valid}, 64'd1);
        chk("replay_out",   {24'd0, bus_a.acc_out},   64'd10);
        chk("replay_count", {56'd0, bus_a.acc_count}, 64'd4);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
